// File: rtl/mult_seq_ctrl.sv
// Sequencer for the shift-add multiplier: button edge detection, the
// load/check/add/shift FSM that drives the external datapath, and the
// wrapping display-window select for the 7-segment mux.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first start press after reset
// LOAD  | load operands and clear the product; the step counter clears
// CHECK | sample z_flag (early exit) and b0 (add or skip)
// ADD   | add the multiplicand into the product
// SHIFT | shift both operands; the last allowed shift ends the multiply
// DONE  | result valid; held until the next start press
module mult_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int SEL_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNC,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       z_flag,
    input  logic       b0,
    output logic       load,
    output logic       add_en,
    output logic       shift_en,
    output logic       busy,
    output logic       done,
    output logic [1:0] sel
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic btnc_q;
    logic btnl_q;
    logic btnr_q;
    logic start_press;
    logic left_press;
    logic right_press;

    // Previous-level registers reset high so a button held through reset
    // release does not register as a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnc_q <= 1'b1;
            btnl_q <= 1'b1;
            btnr_q <= 1'b1;
        end else begin
            btnc_q <= BTNC;
            btnl_q <= BTNL;
            btnr_q <= BTNR;
        end
    end

    assign start_press = BTNC & ~btnc_q;
    assign left_press  = BTNL & ~btnl_q;
    assign right_press = BTNR & ~btnr_q;

    // State and shift-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and shift-count logic; strobes are Moore-decoded below.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start_press) state_nxt = LOAD;
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = CHECK;
            end
            CHECK: begin
                // A zero multiplier ends the multiply regardless of b0.
                if (z_flag)  state_nxt = DONE;
                else if (b0) state_nxt = ADD;
                else         state_nxt = SHIFT;
            end
            ADD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
                else                       state_nxt = CHECK;
            end
            DONE: begin
                if (start_press) state_nxt = LOAD;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the state register only, so reset clears them at once.
    always_comb begin
        load     = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LOAD:  begin load     = 1'b1; busy = 1'b1; end
            CHECK: begin                  busy = 1'b1; end
            ADD:   begin add_en   = 1'b1; busy = 1'b1; end
            SHIFT: begin shift_en = 1'b1; busy = 1'b1; end
            DONE:  begin done     = 1'b1;              end
            default: ;
        endcase
    end

    // Display-window select: left increments, right decrements, both cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= 2'd0;
        end else if (left_press && !right_press) begin
            sel <= (sel == 2'(SEL_MAX)) ? 2'd0 : sel + 2'd1;
        end else if (right_press && !left_press) begin
            sel <= (sel == 2'd0) ? 2'(SEL_MAX) : sel - 2'd1;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;

    localparam int WIDTH   = 8;
    localparam int SEL_MAX = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BTNC = 1'b0;
    logic       BTNL = 1'b0;
    logic       BTNR = 1'b0;
    logic       z_flag;
    logic       b0;
    logic       load;
    logic       add_en;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [1:0] sel;

    mult_seq_ctrl #(.WIDTH(WIDTH), .SEL_MAX(SEL_MAX)) dut (
        .clk(clk), .rst(rst), .BTNC(BTNC), .BTNL(BTNL), .BTNR(BTNR),
        .z_flag(z_flag), .b0(b0), .load(load), .add_en(add_en),
        .shift_en(shift_en), .busy(busy), .done(done), .sel(sel)
    );

    always #5 clk = ~clk;

    // Behavioural datapath driven by the controller's strobes.
    logic [7:0]  a_in = 8'd0;
    logic [7:0]  b_in = 8'd0;
    logic [15:0] dp_a = 16'd0;
    logic [15:0] dp_p = 16'd0;
    logic [7:0]  dp_b = 8'd0;

    always @(posedge clk) begin
        if (load) begin
            dp_a <= {8'd0, a_in};
            dp_b <= b_in;
            dp_p <= 16'd0;
        end else begin
            if (add_en) dp_p <= dp_p + dp_a;
            if (shift_en) begin
                dp_a <= dp_a << 1;
                dp_b <= dp_b >> 1;
            end
        end
    end

    assign z_flag = (dp_b == 8'd0);
    assign b0     = dp_b[0];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int excl_err  = 0;
    int sel_m     = 0;

    task automatic chk(input string name, input int act, input int want);
        total_cnt++;
        if (act == want) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    // Reference: cycles from E0 to DONE, add and shift counts, from the
    // per-bit cost rule (3 for a one, 2 for a zero, 1 for the exit check).
    function automatic void ref_mult(input int m, output int cyc, output int adds, output int shifts);
        cyc = 1; adds = 0; shifts = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (m == 0) begin
                cyc += 1;
                return;
            end
            if (m % 2 == 1) begin
                cyc += 3;
                adds++;
            end else begin
                cyc += 2;
            end
            shifts++;
            m = m / 2;
        end
    endfunction

    // Presses start from a released button, then observes one cycle at a
    // time until done rises. poke pulses BTNC again at E3 and E5.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input bit poke,
                            output int cyc, output int adds, output int shifts,
                            output int busy_n, output string tr);
        a_in = a;
        b_in = b;
        @(negedge clk); BTNC = 1'b0;
        @(negedge clk); BTNC = 1'b1;
        @(posedge clk); #1;
        chk("start_load", int'(load), 1);
        chk("start_done_low", int'(done), 0);
        tr = ""; cyc = -1; adds = 0; shifts = 0; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 1) BTNC = 1'b0;
            if (poke && k == 2) BTNC = 1'b1;
            if (poke && k == 3) BTNC = 1'b0;
            if (poke && k == 4) BTNC = 1'b1;
            if (poke && k == 5) BTNC = 1'b0;
            if (done) begin
                cyc = k;
                break;
            end
            if (int'(load) + int'(add_en) + int'(shift_en) > 1) excl_err++;
            if (busy) busy_n++;
            if (add_en) adds++;
            if (shift_en) shifts++;
            if (load)          tr = {tr, "L"};
            else if (add_en)   tr = {tr, "A"};
            else if (shift_en) tr = {tr, "S"};
            else if (busy)     tr = {tr, "C"};
            else               tr = {tr, "I"};
        end
        if (cyc < 0) chk("done_timeout", 0, 1);
        BTNC = 1'b0;
    endtask

    task automatic press(input logic l, input logic r);
        @(negedge clk); BTNL = l; BTNR = r;
        @(posedge clk); #1;
        BTNL = 1'b0; BTNR = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         prod;
        int         cyc;
        int         adds;
        int         shifts;
        bit         poke;
    } vec_t;

    vec_t  vecs[5];
    int    cyc, adds, shifts, busy_n;
    int    e_cyc, e_adds, e_shifts;
    string tr;

    initial begin
        vecs[0] = '{a: 8'd11,  b: 8'd13,  prod: 143,   cyc: 13, adds: 3, shifts: 4, poke: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd255, prod: 65025, cyc: 25, adds: 8, shifts: 8, poke: 1'b1};
        vecs[2] = '{a: 8'd77,  b: 8'd0,   prod: 0,     cyc: 2,  adds: 0, shifts: 0, poke: 1'b0};
        vecs[3] = '{a: 8'd5,   b: 8'd1,   prod: 5,     cyc: 5,  adds: 1, shifts: 1, poke: 1'b0};
        vecs[4] = '{a: 8'd3,   b: 8'd128, prod: 384,   cyc: 18, adds: 1, shifts: 8, poke: 1'b0};

        // Reset state, before and after clocks in reset.
        #1;
        chk("rst_outputs", int'({load, add_en, shift_en, busy, done}), 0);
        chk("rst_sel", int'(sel), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs_clocked", int'({load, add_en, shift_en, busy, done}), 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start", int'({busy, done}), 0);

        // Directed multiplies, back to back so later ones restart from DONE.
        for (int i = 0; i < 5; i++) begin
            run_mult(vecs[i].a, vecs[i].b, vecs[i].poke, cyc, adds, shifts, busy_n, tr);
            chk("vec_cycles", cyc, vecs[i].cyc);
            chk("vec_adds", adds, vecs[i].adds);
            chk("vec_shifts", shifts, vecs[i].shifts);
            chk("vec_busy_cycles", busy_n, vecs[i].cyc);
            chk("vec_product", int'(dp_p), vecs[i].prod);
            if (i == 0) chk("trace_13", int'(tr == "LCASCSCASCASC"), 1);
            repeat (2) @(posedge clk);
            #1;
            chk("done_held", int'({done, busy}), 2);
        end

        // Randomized multiplies against the reference model.
        for (int i = 0; i < 25; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            ref_mult(int'(rb), e_cyc, e_adds, e_shifts);
            run_mult(ra, rb, 1'b0, cyc, adds, shifts, busy_n, tr);
            chk("rnd_cycles", cyc, e_cyc);
            chk("rnd_adds", adds, e_adds);
            chk("rnd_shifts", shifts, e_shifts);
            chk("rnd_product", int'(dp_p), int'(ra) * int'(rb));
        end
        chk("strobe_exclusive", excl_err, 0);

        // Display select, directed.
        press(1'b1, 1'b0); chk("sel_l1", int'(sel), 1);
        press(1'b1, 1'b0); chk("sel_l2", int'(sel), 2);
        press(1'b1, 1'b0); chk("sel_l3_wrap", int'(sel), 0);
        press(1'b0, 1'b1); chk("sel_r_wrap", int'(sel), 2);
        press(1'b1, 1'b1); chk("sel_both", int'(sel), 2);
        @(negedge clk); BTNL = 1'b1;
        repeat (10) @(posedge clk);
        #1; BTNL = 1'b0;
        @(posedge clk); #1;
        chk("sel_held", int'(sel), 0);

        // Display select, random levels against a press-based model.
        begin
            logic pl, pr, l, r;
            sel_m = 0; pl = 1'b0; pr = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                l = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
                BTNL = l; BTNR = r;
                if (l && !pl && !(r && !pr)) sel_m = (sel_m == SEL_MAX) ? 0 : sel_m + 1;
                if (r && !pr && !(l && !pl)) sel_m = (sel_m == 0) ? SEL_MAX : sel_m - 1;
                pl = l; pr = r;
                @(posedge clk); #1;
                chk("sel_rand", int'(sel), sel_m);
            end
            BTNL = 1'b0; BTNR = 1'b0;
            @(posedge clk); #1;
            for (int i = 0; i < 2 && sel_m == 0; i++) begin
                press(1'b1, 1'b0);
                sel_m = sel_m + 1;
            end
            chk("sel_pre_reset", int'(sel), sel_m);
        end

        // Reset in the middle of ADD with BTNC held through release.
        a_in = 8'd255; b_in = 8'd255;
        @(negedge clk); BTNC = 1'b0;
        @(negedge clk); BTNC = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_add", int'(add_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", int'({load, add_en, shift_en, busy, done}), 0);
        chk("midrst_sel", int'(sel), 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("held_btnc_no_start", int'({load, busy, done}), 0);
        end
        BTNC = 1'b0;
        run_mult(8'd6, 8'd7, 1'b0, cyc, adds, shifts, busy_n, tr);
        ref_mult(7, e_cyc, e_adds, e_shifts);
        chk("post_rst_cycles", cyc, e_cyc);
        chk("post_rst_product", int'(dp_p), 42);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
